// File: rtl/mips_step_ctrl_pkg.sv
// Shared state encodings and widths for the MIPS single-step controller.
package mips_step_ctrl_pkg;

  localparam int unsigned BURST_W = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HALT  = 2'b01,
    ST_STEP  = 2'b10,
    ST_BURST = 2'b11
  } st_e;

endpackage

// File: rtl/mips_step_ctrl_btn_debounce.sv
// Push-button synchroniser + debouncer; emits a one-clk pulse on each accepted press.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_pulse
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic [CW-1:0] cnt;

  // A level must differ from the accepted one for DEBOUNCE_CYCLES consecutive clks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      stable    <= 1'b0;
      cnt       <= '0;
      btn_pulse <= 1'b0;
    end else begin
      s1        <= btn_raw;
      s2        <= s1;
      btn_pulse <= 1'b0;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable    <= s2;
        cnt       <= '0;
        btn_pulse <= s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mips_step_ctrl.sv
// Run/halt/single-step/burst controller gating the MIPS core clock enable.
// Breakpoint logic is built only when MIPS_STEP_BP_EN is defined.
module mips_step_ctrl
  import mips_step_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               pause,
  input  logic               step_btn,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               bp_en,
  input  logic [31:0]        bp_addr,
  input  logic [31:0]        pc,
  output logic               cpu_en,
  output logic [1:0]         state,
  output logic               bp_hit,
  output logic [CNT_W-1:0]   step_cnt
);

  st_e               st;
  st_e               st_n;
  logic [BURST_W-1:0] remaining;
  logic [BURST_W-1:0] rem_n;
  logic              burst_first;
  logic              first_n;
  logic              bp_hit_q;
  logic              bp_hit_n;
  logic              grant;
  logic              p_s1;
  logic              p_s2;
  logic              p_d;
  logic              pause_fall;
  logic              step_pulse;
  logic              tick_ok;
  logic              bp_match;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (step_btn),
    .btn_pulse (step_pulse)
  );

  // Pause synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_s1 <= 1'b0;
      p_s2 <= 1'b0;
      p_d  <= 1'b0;
    end else begin
      p_s1 <= pause;
      p_s2 <= p_s1;
      p_d  <= p_s2;
    end
  end

  assign pause_fall = p_d & ~p_s2;
  // A tick landing right after a grant is dropped so cpu_en never runs back to back.
  assign tick_ok    = tick & ~cpu_en;
  assign state      = 2'(st);

`ifdef MIPS_STEP_BP_EN
  assign bp_match = bp_en && (pc == bp_addr);
  assign bp_hit   = bp_hit_q;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_addr, pc};
  assign bp_match  = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= ST_RUN;
      remaining   <= '0;
      burst_first <= 1'b0;
      bp_hit_q    <= 1'b0;
      cpu_en      <= 1'b0;
      step_cnt    <= '0;
    end else begin
      st          <= st_n;
      remaining   <= rem_n;
      burst_first <= first_n;
      bp_hit_q    <= bp_hit_n;
      cpu_en      <= grant;
      if (grant) step_cnt <= step_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    st_n     = st;
    rem_n    = remaining;
    first_n  = burst_first;
    bp_hit_n = bp_hit_q;
    grant    = 1'b0;
    case (st)
      ST_RUN: begin
        if (p_s2) begin
          st_n = ST_HALT;
        end else if (tick_ok) begin
          if (bp_match) begin
            bp_hit_n = 1'b1;
            st_n     = ST_HALT;
          end else begin
            grant = 1'b1;
          end
        end
      end
      ST_HALT: begin
        if (pause_fall) begin
          st_n     = ST_RUN;
          bp_hit_n = 1'b0;
        end else if (step_pulse && p_s2) begin
          if (burst_len == '0) begin
            st_n     = ST_STEP;
            bp_hit_n = 1'b0;
          end else begin
            st_n    = ST_BURST;
            rem_n   = burst_len;
            first_n = 1'b1;
          end
        end
      end
      ST_STEP: begin
        if (tick_ok) begin
          grant = 1'b1;
          st_n  = ST_HALT;
        end
      end
      ST_BURST: begin
        // The first grant steps off a breakpoint we may have just halted on.
        if (tick_ok) begin
          if (bp_match && !burst_first) begin
            bp_hit_n = 1'b1;
            rem_n    = '0;
            st_n     = ST_HALT;
          end else begin
            grant   = 1'b1;
            first_n = 1'b0;
            rem_n   = remaining - BURST_W'(1);
            if (remaining == BURST_W'(1)) st_n = ST_HALT;
          end
        end
      end
      default: st_n = ST_RUN;
    endcase
  end

endmodule
